// File: rtl/sram_axi_rd_arb_pkg.sv
// Shared definitions for the sram-like to AXI3 read arbiter.
package sram_axi_rd_arb_pkg;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    // Single-beat INCR reads with no lock, cache or protection attributes.
    localparam logic [7:0] ARLEN_SINGLE  = 8'd0;
    localparam logic [1:0] ARBURST_INCR  = 2'b01;
    localparam logic [1:0] ARLOCK_NORMAL = 2'b00;
    localparam logic [3:0] ARCACHE_NONE  = 4'b0000;
    localparam logic [2:0] ARPROT_NONE   = 3'b000;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_AR   = 1'b1
    } state_e;

    // Two byte addresses fall in the same 32-bit word.
    function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/sram_axi_outst_cnt.sv
// Outstanding-read counter for one AXI ID: saturates at MAX_OUTST, never
// drops below zero, and holds its value when inc and dec coincide.
module sram_axi_outst_cnt #(
    parameter int MAX_OUTST = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       inc,
    input  logic       dec,
    output logic [2:0] cnt,
    output logic       full
);

    logic inc_ok;
    logic dec_ok;

    assign full   = (cnt >= 3'(MAX_OUTST));
    assign dec_ok = dec && (cnt != 3'd0);
    assign inc_ok = inc && (!full || dec_ok);

    // Count register; simultaneous inc/dec cancel out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= 3'd0;
        end else begin
            case ({inc_ok, dec_ok})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/sram_axi_rd_arb.sv
// Shares one AXI3 AR/R channel pair between the inst-fetch (ID 0) and data
// (ID 1) sram-like read ports. Data reads that hit a pending write word are
// held back, and a data streak limit keeps inst from starving.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no AR pending; arbitrate eligible requesters, latch winner
// ST_AR   | arvalid high with latched payload, waiting for arready
module sram_axi_rd_arb
    import sram_axi_rd_arb_pkg::*;
#(
    parameter int MAX_OUTST   = 2,
    parameter int DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    input  logic        wr_busy,
    input  logic [31:0] wr_addr,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int STREAK_W = $clog2(DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(DATA_STREAK);

    state_e              state;
    state_e              state_nxt;
    logic [3:0]          ar_id_q;
    logic [31:0]         ar_addr_q;
    size_e               ar_size_q;
    logic [STREAK_W-1:0] streak;
    logic [2:0]          icnt;
    logic [2:0]          dcnt;
    logic                ifull;
    logic                dfull;
    logic                hazard;
    logic                inst_elig;
    logic                data_elig;
    logic                grant_inst;
    logic                grant_data;
    logic                ar_hs;
    logic                unused_r;

    // Response status and sub-word write address bits play no part here.
    assign unused_r = ^{rresp, rlast, wr_addr[1:0]};

    assign hazard     = wr_busy && same_word(wr_addr, data_addr);
    assign inst_elig  = inst_req && !ifull;
    assign data_elig  = data_req && !dfull && !hazard;
    assign grant_data = (state == ST_IDLE) && data_elig && !(inst_elig && (streak >= STREAK_LIMIT));
    assign grant_inst = (state == ST_IDLE) && inst_elig && !grant_data;
    assign ar_hs      = (state == ST_AR) && arready;

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: one grant per visit to IDLE, leave AR on handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_inst || grant_data) state_nxt = ST_AR;
            ST_AR:   if (arready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: arvalid while in AR, addr_ok only on the handshake cycle.
    always_comb begin
        arvalid      = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        if (state == ST_AR) begin
            arvalid      = 1'b1;
            inst_addr_ok = ar_hs && (ar_id_q == ID_INST);
            data_addr_ok = ar_hs && (ar_id_q == ID_DATA);
        end
    end

    // Latch the winner's AR payload; held untouched until the next grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ar_id_q   <= ID_INST;
            ar_addr_q <= 32'd0;
            ar_size_q <= SIZE_BYTE;
        end else if (grant_data) begin
            ar_id_q   <= ID_DATA;
            ar_addr_q <= data_addr;
            ar_size_q <= size_e'(data_size);
        end else if (grant_inst) begin
            ar_id_q   <= ID_INST;
            ar_addr_q <= inst_addr;
            ar_size_q <= size_e'(inst_size);
        end
    end

    // Data-grant streak while inst waits; saturates at the limit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            streak <= '0;
        end else if (!inst_req || grant_inst) begin
            streak <= '0;
        end else if (grant_data && (streak != STREAK_LIMIT)) begin
            streak <= streak + 1'b1;
        end
    end

    sram_axi_outst_cnt #(.MAX_OUTST(MAX_OUTST)) u_icnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (inst_addr_ok),
        .dec  (inst_data_ok),
        .cnt  (icnt),
        .full (ifull)
    );

    sram_axi_outst_cnt #(.MAX_OUTST(MAX_OUTST)) u_dcnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (data_addr_ok),
        .dec  (data_data_ok),
        .cnt  (dcnt),
        .full (dfull)
    );

    // R beats route by ID; beats with nothing outstanding are swallowed.
    assign inst_data_ok = rvalid && (rid == ID_INST) && (icnt != 3'd0);
    assign data_data_ok = rvalid && (rid == ID_DATA) && (dcnt != 3'd0);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;
    assign rready       = 1'b1;

    assign arid    = ar_id_q;
    assign araddr  = ar_addr_q;
    assign arsize  = {1'b0, ar_size_q};
    assign arlen   = ARLEN_SINGLE;
    assign arburst = ARBURST_INCR;
    assign arlock  = ARLOCK_NORMAL;
    assign arcache = ARCACHE_NONE;
    assign arprot  = ARPROT_NONE;

endmodule

// File: doc/sram_axi_rd_arb.md
Name: sram_axi_rd_arb

Overview:
- Read-side arbiter sharing one AXI3 AR/R channel pair between the instruction-fetch and data-memory sram-like requesters.
- Sits between Fetch/Excute sram-like ports and the AXI master boundary of the core.
- Fixed IDs: ID 0 for inst, ID 1 for data. Tracks outstanding reads per ID and routes R beats back by rid.
- Blocks data reads that hit a pending write address (read-after-write hazard).

Parameters:
- MAX_OUTST, 2, maximum outstanding reads per requester. Range 1..7.
- DATA_STREAK, 4, consecutive data grants allowed while inst_req waits, before inst is forced.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- inst_req  in  1  inst read request; held with addr/size until inst_addr_ok
- inst_addr  in  32  inst byte address
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr_ok  out  1  inst request accepted this cycle
- inst_data_ok  out  1  inst read data valid this cycle
- inst_rdata  out  32  inst read data
- data_req  in  1  data read request; held with addr/size until data_addr_ok
- data_addr  in  32  data byte address
- data_size  in  2  as inst_size
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data read data valid this cycle
- data_rdata  out  32  data read data
- wr_busy  in  1  write channel has an outstanding write
- wr_addr  in  32  address of that outstanding write
- arid  out  4  0 = inst, 1 = data
- araddr  out  32  read address
- arlen  out  8  constant 0
- arsize  out  3  {1'b0, size}
- arburst  out  2  constant 2'b01
- arlock  out  2  constant 0
- arcache  out  4  constant 0
- arprot  out  3  constant 0
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  R id
- rdata  in  32  R data
- rresp  in  2  ignored
- rlast  in  1  ignored (single-beat reads only)
- rvalid  in  1  R valid
- rready  out  1  constant 1

Behaviour:
- Reset: state IDLE, arvalid=0, arid/araddr/arsize=0, both outstanding counters=0, streak counter=0. All *_ok outputs are 0.
- FSM state IDLE:
  - Compute eligibility:
    - inst_elig = inst_req && icnt<MAX_OUTST.
    - data_elig = data_req && dcnt<MAX_OUTST && !(wr_busy && wr_addr[31:2]==data_addr[31:2]).
  - Grant data if data_elig and not (inst_elig && streak>=DATA_STREAK). Otherwise grant inst if inst_elig.
  - On grant: register arid/araddr/arsize from the winner, set arvalid=1, go to AR.
  - Streak: +1 on each data grant while inst_req=1; reset to 0 on any inst grant or when inst_req=0.
- FSM state AR:
  - arvalid and the AR payload are held stable until arready.
  - On arvalid&&arready: pulse the granted requester's addr_ok (combinational, same cycle), increment its counter, arvalid=0, return to IDLE.
  - Next grant occurs no earlier than the following cycle. Sustained throughput is 1 AR per 2 cycles.
- R channel:
  - rready is always 1.
  - rvalid&&rid==0&&icnt!=0 → inst_data_ok=1, inst_rdata=rdata (combinational pass-through), icnt decrements.
  - rvalid&&rid==1&&dcnt!=0 → same for data, dcnt decrements.
  - Any other rid, or a beat whose ID counter is 0, is consumed silently with no data_ok.
- Counter arithmetic:
  - Counters are 3 bits.
  - Increment and decrement in the same cycle → value unchanged.
  - A counter never exceeds MAX_OUTST and never wraps below 0.
- Data ordering: per-ID data returns in request order (AXI same-ID ordering). No reorder buffer.
- Hazard: the hazard check is evaluated only in IDLE. Once a request is granted it is not revoked, even if wr_busy rises later.
- Requester dropping req before addr_ok is illegal and undefined.
- Reset mid-operation: asynchronous clear of all state. An AR handshake in flight is abandoned, and R beats arriving afterwards are dropped because the counters are 0.

Decomposition:
- Shared package holds: ID_INST=4'd0, ID_DATA=4'd1, the AR constant fields (ARLEN_SINGLE, ARBURST_INCR, zero lock/cache/prot), the FSM state encodings, and the size encodings.
- One natural sub-module: sram_axi_outst_cnt, a per-ID saturating up/down counter with full flag, instantiated twice.

Test Plan:
- data_req addr 0x1C000100 and inst_req addr 0x1C000000 both asserted in the same cycle, arready=1 → first AR arid=1 araddr=0x1C000100, then arid=0 araddr=0x1C000000. Each addr_ok pulses once.
- wr_busy=1, wr_addr=0x00000204, data_req addr 0x00000206 size 1 → no data grant. Clear wr_busy → AR issued next IDLE cycle with arsize=3'b001.
- Continuous data_req and inst_req, DATA_STREAK=4 → grant pattern is D,D,D,D,I,D,D,D,D,I.
- Hold arready=0 for 5 cycles → arvalid, arid, araddr stable throughout. addr_ok asserts only in the arready cycle.
- Two inst reads issued (icnt=2=MAX_OUTST), third inst_req waits. R beat rid=0 rdata=0xDEADBEEF → inst_data_ok=1 with rdata 0xDEADBEEF. Third request is granted the next cycle.
- Assert rstn=0 mid-AR, then after reset drive R beat rid=1 → data_data_ok stays 0, arvalid=0.
